// File: rtl/motor_ramp_pwm.sv
// Multi-channel PWM motor driver: slew-limited duty ramps plus a safe reversal
// sequence (ramp down, dead time, direction flip, ramp up) per channel.
module motor_ramp_pwm #(
  parameter int N_CH     = 2,
  parameter int DUTY_W   = 10,
  parameter int PRESC    = 4,
  parameter int STEP     = 16,
  parameter int DEAD_PER = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   estop,
  input  logic [N_CH*DUTY_W-1:0] tgt_duty,
  input  logic [N_CH-1:0]        tgt_dir,
  output logic [N_CH-1:0]        pwm,
  output logic [N_CH-1:0]        dir,
  output logic [N_CH-1:0]        at_tgt,
  output logic                   period_st
);

  localparam int PCW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DCW = $clog2(DEAD_PER + 1);
  localparam logic [DUTY_W-1:0]   STEP_D = DUTY_W'(STEP);
  localparam logic signed [DUTY_W:0] STEP_S = {1'b0, STEP_D};

  typedef enum logic [1:0] {RUN, BRAKE, DEAD} state_t;

  logic [PCW-1:0]    presc_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              tick;
  logic              ps;

  state_t            state    [N_CH];
  logic [DUTY_W-1:0] cur_duty [N_CH];
  logic [DCW-1:0]    dead_cnt [N_CH];
  logic [DUTY_W-1:0] eff_duty [N_CH];

  assign tick = (presc_cnt == PCW'(PRESC - 1));
  assign ps   = tick && (pwm_cnt == {DUTY_W{1'b1}});

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      eff_duty[i] = (en && !estop) ? tgt_duty[i*DUTY_W +: DUTY_W] : '0;
    end
  end

  // One slew-limited step toward the target; the signed diff is one bit wider
  // so neither 0 nor full scale can be overshot.
  function automatic logic [DUTY_W-1:0] toward(input logic [DUTY_W-1:0] c,
                                               input logic [DUTY_W-1:0] e);
    logic signed [DUTY_W:0] diff;
    diff = $signed({1'b0, e}) - $signed({1'b0, c});
    if (diff > STEP_S)       return c + STEP_D;
    else if (diff < -STEP_S) return c - STEP_D;
    else                     return e;
  endfunction

  function automatic logic [DUTY_W-1:0] brake_dec(input logic [DUTY_W-1:0] c);
    return (c > STEP_D) ? (c - STEP_D) : '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      period_st <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      period_st <= ps;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm    <= '0;
      dir    <= '0;
      at_tgt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state[i]    <= RUN;
        cur_duty[i] <= '0;
        dead_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pwm[i]    <= !estop && (pwm_cnt < cur_duty[i]);
        at_tgt[i] <= (state[i] == RUN) && (cur_duty[i] == eff_duty[i]) &&
                     (dir[i] == tgt_dir[i]);
        if (estop) begin
          cur_duty[i] <= '0;
          state[i]    <= RUN;
          dead_cnt[i] <= '0;
        end else if (ps) begin
          case (state[i])
            RUN, BRAKE: begin
              if (tgt_dir[i] == dir[i]) begin
                state[i]    <= RUN;
                cur_duty[i] <= toward(cur_duty[i], eff_duty[i]);
              end else begin
                // Reaching zero this period goes straight to dead time.
                cur_duty[i] <= brake_dec(cur_duty[i]);
                state[i]    <= (brake_dec(cur_duty[i]) == '0) ? DEAD : BRAKE;
                dead_cnt[i] <= '0;
              end
            end
            DEAD: begin
              if (tgt_dir[i] == dir[i]) begin
                state[i]    <= RUN;
                cur_duty[i] <= toward(cur_duty[i], eff_duty[i]);
                dead_cnt[i] <= '0;
              end else if (dead_cnt[i] == DCW'(DEAD_PER - 1)) begin
                dir[i]      <= tgt_dir[i];
                state[i]    <= RUN;
                dead_cnt[i] <= '0;
              end else begin
                dead_cnt[i] <= dead_cnt[i] + 1'b1;
              end
            end
            default: state[i] <= RUN;
          endcase
        end
      end
    end
  end

endmodule
